imem_fetch_unit: RTL and testbench

//  Instruction memory and fetch front-end feeding the cpu `inst` input, indexed by cpu `pc`.

---
 rtl/imem_fetch_unit_if.sv | 40 ++++
 rtl/imem_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_imem_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_unit_if.sv
// Load-stream and fetch bundle between a program loader/cpu (master) and imem_fetch_unit (slave).
// Parity ports exist only when IMEM_PARITY_EN is defined.
interface imem_fetch_unit_if #(
    parameter int unsigned ADDR_W = 7
) ();
    logic              load_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W:0]   loaded_count;
    logic              running;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              misalign_err;
    logic [31:0]       fetch_count;
`ifdef IMEM_PARITY_EN
    logic              inject_par;
    logic              parity_err;
`endif

    modport master (
        output load_start, load_valid, load_data, load_last, pc,
`ifdef IMEM_PARITY_EN
        output inject_par,
        input  parity_err,
`endif
        input  load_ready, loaded_count, running, inst, inst_valid, misalign_err, fetch_count
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, pc,
`ifdef IMEM_PARITY_EN
        input  inject_par,
        output parity_err,
`endif
        output load_ready, loaded_count, running, inst, inst_valid, misalign_err, fetch_count
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory loaded over a streaming port, with zero-latency fetch for the IF stage.
// Optional feature macro IMEM_PARITY_EN adds per-word even parity with a sticky parity_err.
module imem_fetch_unit #(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned ADDR_W   = 7,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input logic              clk,
    input logic              reset_n,
    imem_fetch_unit_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]   loaded_count_r;
    logic               misalign_err_r;
    logic [31:0]        fetch_count_r;
    logic [31:0]        mem_r [DEPTH];
    logic               accept_s;
    logic               enter_load_s;
    logic               running_s;
    logic [ADDR_W-1:0]  widx_s;
    logic               in_range_s;
    logic [31:0]        inst_s;
    logic               inst_valid_s;

`ifdef IMEM_PARITY_EN
    logic               mem_par_r [DEPTH];
    logic               parity_err_r;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction
`endif

    assign running_s    = (state_r == ST_RUN);
    assign accept_s     = (state_r == ST_LOAD) && bus.load_valid;
    assign enter_load_s = (next_state_s == ST_LOAD) && (state_r != ST_LOAD);
    assign widx_s       = bus.pc[ADDR_W+1:2];
    assign in_range_s   = running_s && (bus.pc[31:ADDR_W+2] == '0)
                          && ({1'b0, widx_s} < loaded_count_r);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a full array ends the load even without load_last
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load_start) next_state_s = ST_LOAD;
                else                next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (accept_s && (bus.load_last || (wr_ptr_r == ADDR_W'(DEPTH - 32'd1))))
                    next_state_s = ST_RUN;
                else
                    next_state_s = ST_LOAD;
            end
            ST_RUN: begin
                if (bus.load_start) next_state_s = ST_LOAD;
                else                next_state_s = ST_RUN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Load bookkeeping and fetch status; entering LOAD wipes the previous program's view
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r       <= '0;
            loaded_count_r <= '0;
            misalign_err_r <= 1'b0;
            fetch_count_r  <= 32'd0;
        end else if (enter_load_s) begin
            wr_ptr_r       <= '0;
            loaded_count_r <= '0;
            misalign_err_r <= 1'b0;
            fetch_count_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                wr_ptr_r       <= wr_ptr_r + ADDR_W'(1'b1);
                loaded_count_r <= loaded_count_r + CNT_W'(1'b1);
            end
            if (running_s && (bus.pc[1:0] != 2'b00)) begin
                misalign_err_r <= 1'b1;
            end
            if (running_s && inst_valid_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
        end
    end

    // Storage array is deliberately not reset; loaded_count gates visibility
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= bus.load_data;
        end
    end

    // Zero-latency fetch with NOP fill
    always_comb begin
        inst_s       = NOP_WORD;
        inst_valid_s = 1'b0;
        if (in_range_s) begin
            inst_s       = mem_r[widx_s];
            inst_valid_s = 1'b1;
        end else begin
            inst_s       = NOP_WORD;
            inst_valid_s = 1'b0;
        end
    end

`ifdef IMEM_PARITY_EN
    // Parity bit stored alongside each word; inject_par flips it for fault testing
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_par_r[wr_ptr_r] <= even_parity(bus.load_data) ^ bus.inject_par;
        end
    end

    // Sticky parity error on any valid fetch of a corrupted word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_r <= 1'b0;
        end else if (enter_load_s) begin
            parity_err_r <= 1'b0;
        end else if (inst_valid_s && (even_parity(mem_r[widx_s]) != mem_par_r[widx_s])) begin
            parity_err_r <= 1'b1;
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign bus.parity_err = parity_err_r;
`endif

    assign bus.load_ready   = (state_r == ST_LOAD);
    assign bus.loaded_count = loaded_count_r;
    assign bus.running      = running_s;
    assign bus.inst         = inst_s;
    assign bus.inst_valid   = inst_valid_s;
    assign bus.misalign_err = misalign_err_r;
    assign bus.fetch_count  = fetch_count_r;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench for imem_fetch_unit; parity steps run only with IMEM_PARITY_EN.
module tb_imem_fetch_unit;
    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    imem_fetch_unit_if #(.ADDR_W(7)) bus ();

    imem_fetch_unit #(.DEPTH(128), .ADDR_W(7), .NOP_WORD(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        reset_n         = 1'b0;
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = 32'h0;
        bus.load_last   = 1'b0;
        bus.pc          = 32'h0;
`ifdef IMEM_PARITY_EN
        bus.inject_par  = 1'b0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // reset state
        check("rst_running",    32'(bus.running), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_count",      32'(bus.loaded_count), 32'd0);
        check("rst_fetch_cnt",  bus.fetch_count, 32'd0);
        check("rst_misalign",   32'(bus.misalign_err), 32'd0);
        check("rst_inst",       bus.inst, 32'h0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);

        // IDLE ignores load_valid
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEAD_BEEF;
        tick();
        bus.load_valid = 1'b0;
        check("idle_ignore_cnt", 32'(bus.loaded_count), 32'd0);

        // three-word program
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("load_ready_1", 32'(bus.load_ready), 32'd1);
        check("load_running", 32'(bus.running), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hA000_0001 + 32'(i);
            bus.load_last  = (i == 2);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("p3_count",      32'(bus.loaded_count), 32'd3);
        check("p3_running",    32'(bus.running), 32'd1);
        check("p3_load_ready", 32'(bus.load_ready), 32'd0);
        bus.pc = 32'd8;
        #1;
        check("p3_pc8_inst",   bus.inst, 32'hA000_0003);
        check("p3_pc8_valid",  32'(bus.inst_valid), 32'd1);
        bus.pc = 32'd12;
        #1;
        check("p3_pc12_inst",  bus.inst, 32'h0);
        check("p3_pc12_valid", 32'(bus.inst_valid), 32'd0);

        // ten valid fetches, then one out-of-range cycle
        for (int i = 0; i < 10; i++) begin
            bus.pc = 32'((i % 3) * 4);
            tick();
        end
        check("fetch_cnt_10", bus.fetch_count, 32'd10);
        bus.pc = 32'd12;
        tick();
        check("fetch_cnt_hold", bus.fetch_count, 32'd10);

        // misaligned fetch still reads word 1 and counts
        bus.pc = 32'h6;
        #1;
        check("mis_inst",  bus.inst, 32'hA000_0002);
        check("mis_valid", 32'(bus.inst_valid), 32'd1);
        tick();
        check("mis_set", 32'(bus.misalign_err), 32'd1);
        bus.pc = 32'h0;
        tick();
        check("mis_sticky",    32'(bus.misalign_err), 32'd1);
        check("fetch_cnt_12",  bus.fetch_count, 32'd12);

        // reload from RUN clears status
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("reload_running",  32'(bus.running), 32'd0);
        check("reload_fetch",    bus.fetch_count, 32'd0);
        check("reload_misalign", 32'(bus.misalign_err), 32'd0);
        check("reload_count",    32'(bus.loaded_count), 32'd0);
        check("reload_valid",    32'(bus.inst_valid), 32'd0);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("load_start_in_load", 32'(bus.load_ready), 32'd1);

        // fill all 128 words without load_last
        for (int i = 0; i < 128; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hC000_0000 | 32'(i);
            tick();
            if (i == 126) begin
                check("full_m1_ready",   32'(bus.load_ready), 32'd1);
                check("full_m1_running", 32'(bus.running), 32'd0);
            end
        end
        bus.load_data = 32'hBAD0_BAD0;
        tick();
        bus.load_valid = 1'b0;
        check("full_running", 32'(bus.running), 32'd1);
        check("full_ready",   32'(bus.load_ready), 32'd0);
        check("full_count",   32'(bus.loaded_count), 32'd128);
        bus.pc = 32'h1FC;
        #1;
        check("full_1fc_inst",  bus.inst, 32'hC000_007F);
        check("full_1fc_valid", 32'(bus.inst_valid), 32'd1);
        bus.pc = 32'h200;
        #1;
        check("full_200_inst",  bus.inst, 32'h0);
        check("full_200_valid", 32'(bus.inst_valid), 32'd0);
        bus.pc = 32'h8000_0004;
        #1;
        check("full_hi_valid", 32'(bus.inst_valid), 32'd0);
        bus.pc = 32'h0;
        #1;
        check("full_w0_inst", bus.inst, 32'hC000_0000);

        // asynchronous reset in the middle of a load
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h5555_AAAA;
        tick();
        bus.load_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ready",   32'(bus.load_ready), 32'd0);
        check("arst_count",   32'(bus.loaded_count), 32'd0);
        check("arst_running", 32'(bus.running), 32'd0);
        check("arst_inst",    bus.inst, 32'h0);
        check("arst_valid",   32'(bus.inst_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(bus.inst_valid), 32'd0);

`ifdef IMEM_PARITY_EN
        // corrupted parity on word 0 is caught on a valid fetch
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_0007;
        bus.inject_par = 1'b1;
        tick();
        bus.inject_par = 1'b0;
        bus.load_data  = 32'h0000_0003;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.pc = 32'h4;
        tick();
        check("par_clean", 32'(bus.parity_err), 32'd0);
        bus.pc = 32'h0;
        #1;
        check("par_same_cycle", 32'(bus.parity_err), 32'd0);
        tick();
        check("par_set", 32'(bus.parity_err), 32'd1);
        bus.pc = 32'h4;
        tick();
        check("par_held", 32'(bus.parity_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
